// File: rtl/dmem_pkg.sv
// Shared defaults and types for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DmemAddrW     = 10;
  localparam int unsigned DmemDataW     = 16;
  localparam int unsigned DmemWbufDepth = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned DmemPtrW = ptr_width(DmemWbufDepth);

  typedef struct packed {
    logic [DmemAddrW-1:0] addr;
    logic [DmemDataW-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-write FIFO: circular storage, head/tail/count, and a newest-match
// address lookup used for read forwarding.
module dmem_wbuf import dmem_pkg::*; #(
  parameter int unsigned AddrW = DmemAddrW,
  parameter int unsigned DataW = DmemDataW,
  parameter int unsigned Depth = DmemWbufDepth
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [AddrW-1:0] push_addr_i,
  input  logic [DataW-1:0] push_data_i,
  input  logic             pop_i,
  input  logic [AddrW-1:0] lookup_addr_i,
  output logic             lookup_hit_o,
  output logic [DataW-1:0] lookup_data_o,
  output logic [AddrW-1:0] head_addr_o,
  output logic [DataW-1:0] head_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } entry_t;

  entry_t          entries_q [Depth];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o     = (count_q == '0);
  assign full_o      = full_q;
  assign head_addr_o = entries_q[head_q].addr;
  assign head_data_o = entries_q[head_q].data;

  assign do_pop  = ~reset_i & pop_i & ~empty_o;
  assign do_push = ~reset_i & push_i & (~full_q | do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop)  head_d = ptr_inc(head_q);
    if (do_push) tail_d = ptr_inc(tail_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CntW'(Depth));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) entries_q[tail_q] <= '{addr: push_addr_i, data: push_data_i};
  end

  // Walk oldest to newest so the last match seen is the newest one.
  always_comb begin : lookup
    int unsigned slot;
    slot          = 0;
    lookup_hit_o  = 1'b0;
    lookup_data_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      slot = (32'(head_q) + i) % Depth;
      if ((i < 32'(count_q)) && (entries_q[PtrW'(slot)].addr == lookup_addr_i)) begin
        lookup_hit_o  = 1'b1;
        lookup_data_o = entries_q[PtrW'(slot)].data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-ported data memory with registered reads. Define DMEM_WBUF_EN to add
// a posted-write buffer with read forwarding; otherwise writes commit directly.
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned ADDR_W     = DmemAddrW,
  parameter int unsigned DATA_W     = DmemDataW,
  parameter int unsigned WBUF_DEPTH = DmemWbufDepth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic              RE,
  input  logic [ADDR_W-1:0] dataAddress,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              busy
);

  localparam int unsigned Words = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Words];
  logic [DATA_W-1:0] read_data_q;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

`ifdef DMEM_WBUF_EN
  logic              wb_empty, wb_full, drain, push;
  logic [ADDR_W-1:0] wb_head_addr;
  logic [DATA_W-1:0] wb_head_data;

  // The array port is free for a drain only when no array read is needed.
  assign drain = ~reset & ~wb_empty & (~RE | fwd_hit);
  assign push  = ~reset & WE & (~wb_full | drain);

  dmem_wbuf #(
    .AddrW (ADDR_W),
    .DataW (DATA_W),
    .Depth (WBUF_DEPTH)
  ) u_wbuf (
    .clk_i         (clk),
    .reset_i       (reset),
    .push_i        (push),
    .push_addr_i   (dataAddress),
    .push_data_i   (writeData),
    .pop_i         (drain),
    .lookup_addr_i (dataAddress),
    .lookup_hit_o  (fwd_hit),
    .lookup_data_o (fwd_data),
    .head_addr_o   (wb_head_addr),
    .head_data_o   (wb_head_data),
    .empty_o       (wb_empty),
    .full_o        (wb_full)
  );

  assign mem_we    = drain;
  assign mem_waddr = wb_head_addr;
  assign mem_wdata = wb_head_data;
  assign busy      = wb_full;
`else
  assign mem_we    = ~reset & WE;
  assign mem_waddr = dataAddress;
  assign mem_wdata = writeData;
  assign fwd_hit   = 1'b0;
  assign fwd_data  = '0;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Same-edge write is non-blocking, so the read returns pre-write data.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
    end else if (RE) begin
      read_data_q <= fwd_hit ? fwd_data : mem_q[dataAddress];
    end
  end

  assign readData = read_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a queue-based reference model.
module tb_dmem_responder;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned WD = 4;

  logic          clk = 1'b0;
  logic          reset, WE, RE;
  logic [AW-1:0] dataAddress;
  logic [DW-1:0] writeData, readData;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic [DW-1:0] ref_mem [1 << AW];
  ent_t          ref_q [$];
  logic [DW-1:0] ref_rd   = '0;
  logic          ref_busy = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .WBUF_DEPTH (WD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .WE          (WE),
    .RE          (RE),
    .dataAddress (dataAddress),
    .writeData   (writeData),
    .readData    (readData),
    .busy        (busy)
  );

  // One clock edge of the behavioural model.
  task automatic model(input logic rst, input logic we, input logic re,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] val;
`ifdef DMEM_WBUF_EN
    logic hit, drn;
    int   sz;
`endif
    if (rst) begin
      ref_q.delete();
      ref_rd   = '0;
      ref_busy = 1'b0;
      return;
    end
`ifdef DMEM_WBUF_EN
    hit = 1'b0;
    val = ref_mem[a];
    foreach (ref_q[i]) if (ref_q[i].a == a) begin hit = 1'b1; val = ref_q[i].d; end
    sz  = ref_q.size();
    drn = (sz > 0) && (!re || hit);
    if (drn) begin
      ref_mem[ref_q[0].a] = ref_q[0].d;
      void'(ref_q.pop_front());
    end
    if (we && ((sz < WD) || drn)) ref_q.push_back('{a: a, d: d});
    ref_busy = (ref_q.size() == WD);
`else
    val = ref_mem[a];
    if (we) ref_mem[a] = d;
    ref_busy = 1'b0;
`endif
    if (re) ref_rd = val;
  endtask

  task automatic step(input logic rst, input logic we, input logic re,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    reset = rst; WE = we; RE = re; dataAddress = a; writeData = d;
    @(posedge clk);
    model(rst, we, re, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 10'h003, 16'hFFFF);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    checks++;
    if (readData !== 16'h0000) begin
      errors++; $display("FAIL reset_readData: got %h expected %h", readData, 16'h0000);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0);
    end
  endtask

  task automatic init_memory();
    for (int i = 0; i < (1 << AW); i++) step(1'b0, 1'b1, 1'b0, AW'(i), DW'($urandom));
    idle(WD + 1);
    checks++;
    if (busy !== ref_busy) begin
      errors++; $display("FAIL init_busy: got %b expected %b", busy, ref_busy);
    end
  endtask

  task automatic test_forward();
    step(1'b0, 1'b1, 1'b0, 10'h010, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 10'h010, '0);
    checks++;
    if (readData !== 16'h1234) begin
      errors++; $display("FAIL fwd_read: got %h expected %h", readData, 16'h1234);
    end
    step(1'b0, 1'b0, 1'b0, 10'h3FF, '0);
    checks++;
    if (readData !== 16'h1234) begin
      errors++; $display("FAIL read_hold: got %h expected %h", readData, 16'h1234);
    end
  endtask

  task automatic test_full();
    logic exp_busy;
`ifdef DMEM_WBUF_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    idle(WD + 1);
    for (int i = 0; i < WD; i++) begin
      step(1'b0, 1'b1, 1'b1, AW'(10'h100 + i), DW'(16'h0A00 + i));
      checks++;
      if (readData !== ref_rd) begin
        errors++; $display("FAIL full_fill_read%0d: got %h expected %h", i, readData, ref_rd);
      end
    end
    checks++;
    if (busy !== exp_busy) begin
      errors++; $display("FAIL full_busy: got %b expected %b", busy, exp_busy);
    end
    step(1'b0, 1'b1, 1'b1, 10'h005, 16'hBEEF);
    checks++;
    if (busy !== exp_busy) begin
      errors++; $display("FAIL full_discard_busy: got %b expected %b", busy, exp_busy);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL full_release_busy: got %b expected %b", busy, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 10'h005, '0);
    checks++;
    if (readData !== ref_rd) begin
      errors++; $display("FAIL full_discarded: got %h expected %h", readData, ref_rd);
    end
    step(1'b0, 1'b1, 1'b0, 10'h005, 16'hBEEF);
    idle(WD + 1);
    step(1'b0, 1'b0, 1'b1, 10'h005, '0);
    checks++;
    if (readData !== 16'hBEEF) begin
      errors++; $display("FAIL full_retry: got %h expected %h", readData, 16'hBEEF);
    end
    step(1'b0, 1'b0, 1'b1, 10'h100, '0);
    checks++;
    if (readData !== 16'h0A00) begin
      errors++; $display("FAIL full_commit: got %h expected %h", readData, 16'h0A00);
    end
  endtask

  task automatic test_same_addr();
    idle(WD + 1);
    step(1'b0, 1'b1, 1'b1, 10'h020, 16'h0001);
    step(1'b0, 1'b1, 1'b1, 10'h020, 16'h0002);
    step(1'b0, 1'b0, 1'b1, 10'h020, '0);
    checks++;
    if (readData !== 16'h0002) begin
      errors++; $display("FAIL same_addr_fwd: got %h expected %h", readData, 16'h0002);
    end
    idle(WD + 1);
    step(1'b0, 1'b0, 1'b1, 10'h020, '0);
    checks++;
    if (readData !== 16'h0002) begin
      errors++; $display("FAIL same_addr_array: got %h expected %h", readData, 16'h0002);
    end
  endtask

  task automatic test_rw_same_edge();
    step(1'b0, 1'b1, 1'b0, 10'h030, 16'hAAAA);
    idle(WD + 1);
    step(1'b0, 1'b1, 1'b1, 10'h030, 16'h5555);
    checks++;
    if (readData !== 16'hAAAA) begin
      errors++; $display("FAIL rw_old_data: got %h expected %h", readData, 16'hAAAA);
    end
    step(1'b0, 1'b0, 1'b1, 10'h030, '0);
    checks++;
    if (readData !== 16'h5555) begin
      errors++; $display("FAIL rw_new_data: got %h expected %h", readData, 16'h5555);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] prior [3];
    logic [DW-1:0] fresh [3];
    logic [DW-1:0] exp;
    for (int i = 0; i < 3; i++) begin
      prior[i] = DW'(16'h0111 * (i + 1));
      fresh[i] = DW'(16'hD000 + i);
      step(1'b0, 1'b1, 1'b0, AW'(10'h040 + i), prior[i]);
    end
    idle(WD + 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, AW'(10'h040 + i), fresh[i]);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_busy: got %b expected %b", busy, 1'b0);
    end
    checks++;
    if (readData !== 16'h0000) begin
      errors++; $display("FAIL mid_reset_readData: got %h expected %h", readData, 16'h0000);
    end
    for (int i = 0; i < 3; i++) begin
`ifdef DMEM_WBUF_EN
      exp = prior[i];
`else
      exp = fresh[i];
`endif
      step(1'b0, 1'b0, 1'b1, AW'(10'h040 + i), '0);
      checks++;
      if (readData !== exp) begin
        errors++; $display("FAIL mid_reset_read%0d: got %h expected %h", i, readData, exp);
      end
    end
  endtask

  task automatic test_random();
    logic rst, we, re;
    logic [AW-1:0] a;
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      a   = 10'h200 | AW'($urandom_range(0, 7));
      step(rst, we, re, a, DW'($urandom));
      checks++;
      if (readData !== ref_rd) begin
        errors++; $display("FAIL rand_read@%0d: got %h expected %h", n, readData, ref_rd);
      end
      checks++;
      if (busy !== ref_busy) begin
        errors++; $display("FAIL rand_busy@%0d: got %b expected %b", n, busy, ref_busy);
      end
    end
  endtask

  initial begin
    reset = 1'b1; WE = 1'b0; RE = 1'b0; dataAddress = '0; writeData = '0;
    test_reset();
    init_memory();
    test_forward();
    test_full();
    test_same_addr();
    test_rw_same_edge();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
